// File: rtl/text_buf_pkg.sv
// rtl/text_buf_pkg.sv - shared FSM state type and default geometry/fill constants for text_buf
package text_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  localparam int             DEF_COLS = 160;
  localparam int             DEF_ROWS = 64;
  localparam int             DEF_CW   = 8;
  localparam logic [7:0]     DEF_FILL = 8'h20;

endpackage

// File: rtl/text_buf_ram.sv
// rtl/text_buf_ram.sv - simple dual-port character store, one write port and one registered read port
module text_buf_ram #(
  parameter int AW = 14,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [0:(1<<AW)-1];

  // Both ports update on the same edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/text_buf.sv
// rtl/text_buf.sv - scrolling text buffer: row-rotated addressing, 2-cycle reads, clear/scroll fill engine
module text_buf
  import text_buf_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int CW   = DEF_CW,
  parameter int AW   = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [7:0]    rd_row,
  input  logic [7:0]    rd_col,
  output logic [CW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [7:0]    wr_row,
  input  logic [7:0]    wr_col,
  input  logic [CW-1:0] wr_data,
  input  logic          scroll_up,
  input  logic          clr_start,
  input  logic [CW-1:0] fill_char,
  output logic          busy,
  output logic          wr_drop
);

  localparam logic [8:0]    ROWS_N   = 9'(ROWS);
  localparam logic [8:0]    COLS_N   = 9'(COLS);
  localparam logic [7:0]    TOP_LAST = 8'(ROWS - 1);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] LAST_ALL = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(COLS - 1);

  state_t        state;
  logic [7:0]    top;
  logic [AW-1:0] cnt;
  logic [AW-1:0] row_base;
  logic [CW-1:0] fill_q;

  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [CW-1:0] ram_wd;
  logic          ram_re;
  logic [CW-1:0] ram_q;

  logic          rd_ok;
  logic          wr_ok;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          rd_pend;
  logic          rd_oob;

  // Logical row is rotated by top; both operands are < ROWS so one subtract does the modulo.
  function automatic logic [AW-1:0] cell_addr(input logic [7:0] row, input logic [7:0] col,
                                              input logic [7:0] base);
    logic [8:0] sum;
    logic [8:0] phys;
    sum  = {1'b0, row} + {1'b0, base};
    phys = (sum >= ROWS_N) ? sum - ROWS_N : sum;
    return AW'(phys) * COLS_A + AW'(col);
  endfunction

  always_comb begin
    rd_ok   = ({1'b0, rd_row} < ROWS_N) && ({1'b0, rd_col} < COLS_N);
    wr_ok   = ({1'b0, wr_row} < ROWS_N) && ({1'b0, wr_col} < COLS_N);
    rd_addr = cell_addr(rd_row, rd_col, top);
    wr_addr = cell_addr(wr_row, wr_col, top);
    ram_re  = rd_en && rd_ok;
  end

  text_buf_ram #(
    .AW (AW),
    .CW (CW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_wa),
    .wdata (ram_wd),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Stage 1 is the RAM read itself; stage 2 registers the result or forces 0 for out-of-range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_oob   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= rd_en;
      rd_oob   <= !rd_ok;
      rd_valid <= rd_pend;
      rd_data  <= (rd_pend && !rd_oob) ? ram_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      top      <= 8'd0;
      cnt      <= '0;
      row_base <= '0;
      fill_q   <= '0;
      ram_we   <= 1'b0;
      ram_wa   <= '0;
      ram_wd   <= '0;
      wr_drop  <= 1'b0;
    end else begin
      ram_we  <= 1'b0;
      wr_drop <= wr_en && wr_ok && (state != IDLE);
      case (state)
        IDLE: begin
          if (wr_en && wr_ok) begin
            ram_we <= 1'b1;
            ram_wa <= wr_addr;
            ram_wd <= wr_data;
          end
          if (clr_start) begin
            top    <= 8'd0;
            fill_q <= fill_char;
            cnt    <= '0;
            state  <= CLR_ALL;
            busy   <= 1'b1;
          end else if (scroll_up) begin
            // The old top physical row becomes the new last logical row.
            top      <= (top == TOP_LAST) ? 8'd0 : top + 8'd1;
            row_base <= AW'(top) * COLS_A;
            fill_q   <= fill_char;
            cnt      <= '0;
            state    <= CLR_ROW;
            busy     <= 1'b1;
          end
        end
        CLR_ALL: begin
          ram_we <= 1'b1;
          ram_wa <= cnt;
          ram_wd <= fill_q;
          if (cnt == LAST_ALL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLR_ROW: begin
          ram_we <= 1'b1;
          ram_wa <= row_base + cnt;
          ram_wd <= fill_q;
          if (cnt == LAST_ROW) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buf.sv
// tb/tb_text_buf.sv - directed self-checking bench for text_buf
module tb_text_buf;

  localparam int COLS = 160;
  localparam int ROWS = 64;
  localparam int CW   = 8;
  localparam int AW   = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_row = 8'd0;
  logic [7:0]    rd_col = 8'd0;
  logic [CW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_row = 8'd0;
  logic [7:0]    wr_col = 8'd0;
  logic [CW-1:0] wr_data = '0;
  logic          scroll_up = 1'b0;
  logic          clr_start = 1'b0;
  logic [CW-1:0] fill_char = '0;
  logic          busy;
  logic          wr_drop;

  int total = 0;
  int bad   = 0;

  text_buf #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .scroll_up (scroll_up),
    .clr_start (clr_start),
    .fill_char (fill_char),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d,
                    output logic drop);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    tick();
    drop  = wr_drop;
    wr_en = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [7:0] r, input logic [7:0] c, output logic [7:0] d,
                    output logic v);
    rd_en = 1'b1; rd_row = r; rd_col = c;
    tick();
    rd_en = 1'b0;
    tick();
    d = rd_data;
    v = rd_valid;
  endtask

  // Extra cycle at the end lets the last fill write land before any read.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20000) begin
      n++;
      tick();
    end
    tick();
  endtask

  task automatic cmd(input logic clr, input logic scr, input logic [7:0] f, output int n);
    clr_start = clr; scroll_up = scr; fill_char = f;
    tick();
    clr_start = 1'b0; scroll_up = 1'b0;
    wait_idle(n);
  endtask

  // Pipelined scan of rows lo..hi; expected cell value is base + step*row.
  task automatic scan(input int lo, input int hi, input logic [7:0] base, input logic [7:0] step,
                      output int errs);
    int n;
    int k;
    logic [7:0] e;
    n = (hi - lo + 1) * COLS;
    errs = 0;
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        rd_en = 1'b1; rd_row = 8'(lo + j / COLS); rd_col = 8'(j % COLS);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (j >= 1) begin
        k = j - 1;
        e = base + step * 8'(lo + k / COLS);
        if (!rd_valid || rd_data !== e) errs++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       v;
    logic       drop;
    int         n;
    int         errs;
    int         badlen;

    repeat (3) tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_drop", wr_drop, 0);
    check("rst_top", dut.top, 0);
    rst_n = 1'b1;
    tick();

    wr(8'd3, 8'd5, 8'h41, drop);
    check("wr_no_drop", drop, 0);
    rd_en = 1'b1; rd_row = 8'd3; rd_col = 8'd5;
    tick();
    rd_en = 1'b0;
    check("lat_n1_valid", rd_valid, 0);
    tick();
    check("lat_n2_valid", rd_valid, 1);
    check("lat_n2_data", rd_data, 8'h41);
    tick();
    check("lat_n3_valid", rd_valid, 0);

    // clr_start and scroll_up together: clear must win.
    cmd(1'b1, 1'b1, 8'h20, n);
    check("clr_busy_len", n, COLS * ROWS);
    check("clr_top", dut.top, 0);
    scan(0, ROWS - 1, 8'h20, 8'h00, errs);
    check("clr_cells", errs, 0);

    wr(8'd2, 8'd2, 8'h55, drop);
    wr_en = 1'b1; wr_row = 8'd2; wr_col = 8'd2; wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_row = 8'd2; rd_col = 8'd2;
    tick();
    rd_en = 1'b0;
    tick();
    check("read_first_old", rd_data, 8'h55);
    rd(8'd2, 8'd2, d, v);
    check("read_first_new", d, 8'h66);

    wr(8'd1, 8'd0, 8'h42, drop);
    cmd(1'b0, 1'b1, 8'h81, n);
    check("scroll_busy_len", n, COLS);
    check("scroll_top", dut.top, 1);
    rd(8'd0, 8'd0, d, v);
    check("scroll_row0", d, 8'h42);
    rd(8'd0, 8'd1, d, v);
    check("scroll_row0_c1", d, 8'h20);
    scan(ROWS - 1, ROWS - 1, 8'h81, 8'h00, errs);
    check("scroll_last_row", errs, 0);

    badlen = 0;
    for (int k = 2; k <= ROWS; k++) begin
      cmd(1'b0, 1'b1, 8'(8'h80 + k), n);
      if (n != COLS) badlen++;
    end
    check("wrap_busy_lens", badlen, 0);
    check("wrap_top", dut.top, 0);
    scan(0, ROWS - 1, 8'h81, 8'h01, errs);
    check("wrap_rows", errs, 0);

    scroll_up = 1'b1; fill_char = 8'hC1;
    tick();
    scroll_up = 1'b0;
    check("busy_after_scroll", busy, 1);
    wr(8'd10, 8'd3, 8'h99, drop);
    check("drop_pulse", drop, 1);
    check("drop_single", wr_drop, 0);
    scroll_up = 1'b1;
    tick();
    scroll_up = 1'b0;
    wait_idle(n);
    check("busy_ignore_len", n + 3, COLS);
    check("busy_ignore_top", dut.top, 1);
    rd(8'd10, 8'd3, d, v);
    check("dropped_cell", d, 8'h8C);
    rd(8'd63, 8'd0, d, v);
    check("scroll65_last", d, 8'hC1);

    rd(8'd200, 8'd0, d, v);
    check("oob_row_valid", v, 1);
    check("oob_row_data", d, 0);
    rd(8'd0, 8'd160, d, v);
    check("oob_col_valid", v, 1);
    check("oob_col_data", d, 0);
    wr(8'd70, 8'd0, 8'h11, drop);
    check("oob_wr_no_drop", drop, 0);

    clr_start = 1'b1; fill_char = 8'h30;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    check("mid_clr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_abort_busy", busy, 0);
    check("rst_abort_top", dut.top, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cmd(1'b0, 1'b1, 8'h31, n);
    check("post_rst_scroll_len", n, COLS);
    rd(8'd63, 8'd5, d, v);
    check("post_rst_scroll_fill", d, 8'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
